csr_access_unit: RTL and testbench
==================================

Name: csr_access_unit

Overview:
Executes Zicsr instructions (CSRRW/S/C and immediate forms) handed over by the execute stage.
- Read phase: drives the CSR address to the CSR banks and captures the old value.
- Write phase: computes the read-modify-write result, checks privilege and legality, then issues a single-cycle write strobe with per-register selects to the scratch CSR bank (mscratch/sscratch) and a broadcast strobe to other banks.
- Returns the old CSR value, or an illegal-instruction flag, to writeback over a valid/ready handshake.

Parameters:
- XLEN, 64, data width of CSRs and operands.
- MSCRATCH_ADDR, 12'h340, address decoded to mrw_mscratch_sel.
- SSCRATCH_ADDR, 12'h140, address decoded to srw_sscratch_sel.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  CSR op offered
- req_ready  out  1  unit can accept (high only in IDLE)
- req_op  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- req_addr  in  12  CSR address
- req_rs1_data  in  XLEN  rs1 value
- req_uimm  in  5  zimm field
- req_rs1_zero  in  1  rs1 index == x0
- priv  in  2  current privilege: 11 M, 01 S, 00 U
- csr_raddr  out  12  registered CSR address to banks
- csr_rdata  in  XLEN  combinational read data for csr_raddr
- csr_ext_hit  in  1  another bank claims csr_raddr
- mrw_mscratch_sel  out  1  csr_raddr == MSCRATCH_ADDR, asserted in WRITE only
- srw_sscratch_sel  out  1  csr_raddr == SSCRATCH_ADDR, asserted in WRITE only
- csr_write  out  1  write strobe
- data_csr  out  XLEN  write data
- rsp_valid  out  1  result available
- rsp_ready  in  1  writeback accepts
- rsp_rdata  out  XLEN  old CSR value (0 if illegal)
- rsp_illegal  out  1  raise illegal-instruction exception

Behaviour:
- Reset: rst is asynchronous and active-high. It forces state IDLE and clears all registered outputs: csr_raddr=0, csr_write=0, both sels=0, data_csr=0, rsp_valid=0, rsp_rdata=0, rsp_illegal=0.
- Reset mid-operation aborts the op. No write is issued, even when reset lands in WRITE.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture op/addr/rs1_data/uimm/rs1_zero/priv; csr_raddr<=req_addr; go to READ.
- READ:
  - Register old_q<=csr_rdata.
  - Compute wr_en: RW/RWI always; RS/RC when !rs1_zero; RSI/RCI when uimm!=0.
  - Compute illegal if any of:
    - op is 000 or 100;
    - addr[9:8] > captured priv;
    - addr[11:10]==2'b11 && wr_en;
    - addr matches neither scratch address and !csr_ext_hit.
  - If illegal: rsp_illegal<=1, rsp_rdata<=0, go to RESP.
  - Else if !wr_en: rsp_rdata<=csr_rdata, go to RESP.
  - Else: data_csr<=new value, go to WRITE.
- New value, with operand = rs1_data for register forms or zero-extended uimm for immediate forms:
  - RW: operand.
  - RS: old | operand.
  - RC: old & ~operand.
- WRITE:
  - csr_write=1 for exactly this one cycle.
  - Sel decoded from csr_raddr; at most one sel high. csr_raddr is held.
  - rsp_rdata<=old_q; go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_illegal stay stable until rsp_ready.
  - On rsp_ready, go to IDLE with rsp_valid<=0.
  - Back-to-back requests are not accepted in the same cycle as the response.
- Latency from the accept edge:
  - rsp_valid rises 2 cycles after accept for illegal or read-only ops.
  - rsp_valid rises 3 cycles after accept for writing ops.
- No pipelining; one op in flight.
- Sels and csr_write are 0 in every state except WRITE.

Decomposition:
- Package csr_pkg holds:
  - funct3 op constants;
  - privilege encodings;
  - MSCRATCH/SSCRATCH address constants;
  - the state enum (2-bit).
- One combinational sub-module, csr_rmw: inputs op, old, rs1_data, uimm, rs1_zero; outputs new value and wr_en.
- Legality check and FSM live in the top module.

Test Plan:
1. Priv=11, CSRRW 0x340, rs1_data=0xDEADBEEF, csr_rdata=0x5.
   - Expect: in WRITE, csr_write=1, mrw_mscratch_sel=1, data_csr=0xDEADBEEF.
   - Expect: rsp_rdata=0x5 and rsp_illegal=0, with rsp_valid 3 cycles after accept.
2. Priv=01, CSRRS 0x140, rs1_zero=1, csr_rdata=0xA5.
   - Expect: no csr_write; rsp_rdata=0xA5 after 2 cycles.
3. Priv=01, CSRRC 0x340.
   - Expect: rsp_illegal=1, rsp_rdata=0, no csr_write.
4. Priv=11, CSRRSI 0x140, uimm=5'h12, old=0x01.
   - Expect: data_csr=0x13, srw_sscratch_sel=1.
   - Then CSRRCI on the same address, uimm=5'h03, old=0x13: expect data_csr=0x10.
5. Hold rsp_ready=0 for 4 cycles in RESP.
   - Expect: rsp_valid and rsp_rdata stable, req_ready=0, a new req_valid ignored.
   - On release, IDLE; the next request is accepted.
6. Assert rst asynchronously mid-cycle during WRITE.
   - Expect: csr_write, sels and rsp_valid go to 0 immediately; state IDLE; req_ready=1 after rst falls.

Source files
------------

// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_pkg
// Description : Shared constants and state type for the Zicsr access unit.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_pkg;

    localparam logic [2:0] c_OP_RW  = 3'b001;
    localparam logic [2:0] c_OP_RS  = 3'b010;
    localparam logic [2:0] c_OP_RC  = 3'b011;
    localparam logic [2:0] c_OP_RWI = 3'b101;
    localparam logic [2:0] c_OP_RSI = 3'b110;
    localparam logic [2:0] c_OP_RCI = 3'b111;

    localparam logic [1:0] c_PRIV_U = 2'b00;
    localparam logic [1:0] c_PRIV_S = 2'b01;
    localparam logic [1:0] c_PRIV_M = 2'b11;

    localparam logic [11:0] c_MSCRATCH_ADDR = 12'h340;
    localparam logic [11:0] c_SSCRATCH_ADDR = 12'h140;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/csr_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_access_unit_if
// Description : Request, CSR-bank and response signals of the CSR access unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_access_unit_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [11:0]     req_addr;
    logic [XLEN-1:0] req_rs1_data;
    logic [4:0]      req_uimm;
    logic            req_rs1_zero;
    logic [1:0]      priv;
    logic [11:0]     csr_raddr;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_ext_hit;
    logic            mrw_mscratch_sel;
    logic            srw_sscratch_sel;
    logic            csr_write;
    logic [XLEN-1:0] data_csr;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_illegal;

    modport slave (
        input  req_valid, req_op, req_addr, req_rs1_data, req_uimm, req_rs1_zero,
               priv, csr_rdata, csr_ext_hit, rsp_ready,
        output req_ready, csr_raddr, mrw_mscratch_sel, srw_sscratch_sel,
               csr_write, data_csr, rsp_valid, rsp_rdata, rsp_illegal
    );

    modport master (
        output req_valid, req_op, req_addr, req_rs1_data, req_uimm, req_rs1_zero,
               priv, csr_rdata, csr_ext_hit, rsp_ready,
        input  req_ready, csr_raddr, mrw_mscratch_sel, srw_sscratch_sel,
               csr_write, data_csr, rsp_valid, rsp_rdata, rsp_illegal
    );
endinterface
`default_nettype wire

// File: rtl/csr_rmw.sv
`default_nettype none
// ============================================================================
// Module      : csr_rmw
// Description : Read-modify-write result and write-enable for Zicsr ops.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_rmw
    import csr_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  wire logic [2:0]      op,
    input  wire logic [XLEN-1:0] old,
    input  wire logic [XLEN-1:0] rs1_data,
    input  wire logic [4:0]      uimm,
    input  wire logic            rs1_zero,
    output logic      [XLEN-1:0] new_val,
    output logic                 wr_en
);
    logic [XLEN-1:0] w_operand;

    assign w_operand = op[2] ? {{(XLEN-5){1'b0}}, uimm} : rs1_data;

    // Set/clear forms with a zero source are pure reads and must not write.
    always_comb begin
        new_val = w_operand;
        wr_en   = 1'b0;
        case (op)
            c_OP_RW, c_OP_RWI: begin
                new_val = w_operand;
                wr_en   = 1'b1;
            end
            c_OP_RS: begin
                new_val = old | w_operand;
                wr_en   = !rs1_zero;
            end
            c_OP_RC: begin
                new_val = old & ~w_operand;
                wr_en   = !rs1_zero;
            end
            c_OP_RSI: begin
                new_val = old | w_operand;
                wr_en   = (uimm != 5'd0);
            end
            c_OP_RCI: begin
                new_val = old & ~w_operand;
                wr_en   = (uimm != 5'd0);
            end
            default: begin
                new_val = old;
                wr_en   = 1'b0;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/csr_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : csr_access_unit
// Description : Executes one Zicsr instruction at a time: read, check, write, respond.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int          XLEN          = 64,
    parameter logic [11:0] MSCRATCH_ADDR = c_MSCRATCH_ADDR,
    parameter logic [11:0] SSCRATCH_ADDR = c_SSCRATCH_ADDR
) (
    input wire logic         clk,
    input wire logic         rst,
    csr_access_unit_if.slave bus
);
    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_rs1_data;
    logic [4:0]      r_uimm;
    logic            r_rs1_zero;
    logic [1:0]      r_priv;
    logic [11:0]     r_raddr;
    logic [XLEN-1:0] r_old;
    logic [XLEN-1:0] r_data;
    logic [XLEN-1:0] r_rdata;
    logic            r_illegal;

    logic [XLEN-1:0] w_new;
    logic            w_wr_en;
    logic            w_hit_m;
    logic            w_hit_s;
    logic            w_op_bad;
    logic            w_illegal;

    csr_rmw #(.XLEN(XLEN)) u_rmw (
        .op       (r_op),
        .old      (bus.csr_rdata),
        .rs1_data (r_rs1_data),
        .uimm     (r_uimm),
        .rs1_zero (r_rs1_zero),
        .new_val  (w_new),
        .wr_en    (w_wr_en)
    );

    assign w_hit_m   = (r_raddr == MSCRATCH_ADDR);
    assign w_hit_s   = (r_raddr == SSCRATCH_ADDR);
    assign w_op_bad  = (r_op == 3'b000) || (r_op == 3'b100);
    // addr[11:10]==11 marks read-only CSRs; addr[9:8] is the lowest privilege allowed.
    assign w_illegal = w_op_bad
                     || (r_raddr[9:8] > r_priv)
                     || ((r_raddr[11:10] == 2'b11) && w_wr_en)
                     || (!w_hit_m && !w_hit_s && !bus.csr_ext_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Strobes decode from state so an asynchronous reset drops them at once.
    always_comb begin
        w_next               = r_state;
        bus.req_ready        = 1'b0;
        bus.csr_write        = 1'b0;
        bus.mrw_mscratch_sel = 1'b0;
        bus.srw_sscratch_sel = 1'b0;
        bus.rsp_valid        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) w_next = ST_READ;
            end
            ST_READ: begin
                w_next = (w_illegal || !w_wr_en) ? ST_RESP : ST_WRITE;
            end
            ST_WRITE: begin
                bus.csr_write        = 1'b1;
                bus.mrw_mscratch_sel = w_hit_m;
                bus.srw_sscratch_sel = w_hit_s;
                w_next               = ST_RESP;
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op       <= 3'd0;
            r_rs1_data <= '0;
            r_uimm     <= 5'd0;
            r_rs1_zero <= 1'b0;
            r_priv     <= 2'd0;
            r_raddr    <= 12'd0;
            r_old      <= '0;
            r_data     <= '0;
            r_rdata    <= '0;
            r_illegal  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_op       <= bus.req_op;
                        r_rs1_data <= bus.req_rs1_data;
                        r_uimm     <= bus.req_uimm;
                        r_rs1_zero <= bus.req_rs1_zero;
                        r_priv     <= bus.priv;
                        r_raddr    <= bus.req_addr;
                    end
                end
                ST_READ: begin
                    r_old <= bus.csr_rdata;
                    if (w_illegal) begin
                        r_illegal <= 1'b1;
                        r_rdata   <= '0;
                    end else if (!w_wr_en) begin
                        r_illegal <= 1'b0;
                        r_rdata   <= bus.csr_rdata;
                    end else begin
                        r_illegal <= 1'b0;
                        r_data    <= w_new;
                    end
                end
                ST_WRITE: r_rdata <= r_old;
                default: ;
            endcase
        end
    end

    assign bus.csr_raddr   = r_raddr;
    assign bus.data_csr    = r_data;
    assign bus.rsp_rdata   = r_rdata;
    assign bus.rsp_illegal = r_illegal;
endmodule
`default_nettype wire

// File: tb/tb_csr_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_access_unit
// Description : Self-checking bench for csr_access_unit with a CSR bank model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_access_unit;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    logic [63:0] bank    [0:4095];
    logic [63:0] ref_mem [0:4095];
    bit          ext_map [0:4095];

    int          o_lat;
    int          o_wcount;
    logic [63:0] o_wdata;
    logic [63:0] o_rdata;
    logic        o_wsel_m;
    logic        o_wsel_s;
    logic        o_ill;
    bit          o_stray;
    bit          o_stable;
    bit          o_idle;
    bit          o_timeout;

    csr_access_unit_if #(.XLEN(64)) bus ();

    csr_access_unit #(.XLEN(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.csr_rdata   = bank[bus.csr_raddr];
    assign bus.csr_ext_hit = ext_map[bus.csr_raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one op, records what the DUT did, optionally stalls the response.
    task automatic do_op(input logic [2:0] op, input logic [11:0] addr, input logic [63:0] rs1,
                         input logic [4:0] uimm, input logic rs1z, input logic [1:0] pv,
                         input int hold, input bit poke);
        int  n;
        bit  seen;
        o_lat = 0; o_wcount = 0; o_wdata = '0; o_rdata = '0; o_wsel_m = 0; o_wsel_s = 0;
        o_ill = 0; o_stray = 0; o_stable = 1; o_idle = 0; o_timeout = 0;
        n = 0;
        while (!bus.req_ready && n < 20) begin @(posedge clk); #1; n++; end
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr; bus.req_rs1_data = rs1;
        bus.req_uimm = uimm; bus.req_rs1_zero = rs1z; bus.priv = pv;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 1; seen = 0;
        while (!seen && n < 20) begin
            if (bus.csr_write) begin
                o_wcount++;
                o_wdata = bus.data_csr; o_wsel_m = bus.mrw_mscratch_sel; o_wsel_s = bus.srw_sscratch_sel;
                bank[bus.csr_raddr] = bus.data_csr;
            end else if (bus.mrw_mscratch_sel || bus.srw_sscratch_sel) begin
                o_stray = 1;
            end
            if (bus.rsp_valid) begin
                seen = 1; o_lat = n; o_rdata = bus.rsp_rdata; o_ill = bus.rsp_illegal;
            end else begin
                @(posedge clk); #1; n++;
            end
        end
        if (!seen) o_timeout = 1;
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                bus.req_valid = 1'b1; bus.req_addr = 12'($urandom); bus.req_op = 3'b001;
            end
            @(posedge clk); #1;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== o_rdata || bus.rsp_illegal !== o_ill
                || bus.req_ready !== 1'b0 || bus.csr_raddr !== addr || bus.csr_write !== 1'b0)
                o_stable = 0;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        o_idle = bus.req_ready && !bus.rsp_valid;
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_cmp++; if (bus.csr_write !== 1'b0 || bus.mrw_mscratch_sel !== 1'b0 || bus.srw_sscratch_sel !== 1'b0) begin
            n_bad++; $display("FAIL reset_strobes: got %b%b%b want 000", bus.csr_write, bus.mrw_mscratch_sel, bus.srw_sscratch_sel); end
        n_cmp++; if (bus.csr_raddr !== 12'd0) begin n_bad++; $display("FAIL reset_raddr: got %h want 000", bus.csr_raddr); end
        n_cmp++; if (bus.data_csr !== 64'd0 || bus.rsp_rdata !== 64'd0 || bus.rsp_illegal !== 1'b0) begin
            n_bad++; $display("FAIL reset_data: got %h/%h/%b want 0/0/0", bus.data_csr, bus.rsp_rdata, bus.rsp_illegal); end
    endtask

    task automatic test_csrrw_mscratch();
        bank[12'h340] = 64'h5; ref_mem[12'h340] = 64'h5;
        do_op(3'b001, 12'h340, 64'hDEADBEEF, 5'd0, 1'b0, 2'b11, 0, 0);
        ref_mem[12'h340] = 64'hDEADBEEF;
        n_cmp++; if (o_wcount !== 1 || o_wsel_m !== 1'b1 || o_wsel_s !== 1'b0) begin
            n_bad++; $display("FAIL rw_write: got cnt=%0d m=%b s=%b want cnt=1 m=1 s=0", o_wcount, o_wsel_m, o_wsel_s); end
        n_cmp++; if (o_wdata !== 64'hDEADBEEF) begin n_bad++; $display("FAIL rw_data: got %h want deadbeef", o_wdata); end
        n_cmp++; if (o_rdata !== 64'h5 || o_ill !== 1'b0) begin n_bad++; $display("FAIL rw_rsp: got %h/%b want 5/0", o_rdata, o_ill); end
        n_cmp++; if (o_lat !== 3) begin n_bad++; $display("FAIL rw_latency: got %0d want 3", o_lat); end
    endtask

    task automatic test_read_only();
        bank[12'h140] = 64'hA5; ref_mem[12'h140] = 64'hA5;
        do_op(3'b010, 12'h140, 64'hFFFF, 5'd0, 1'b1, 2'b01, 0, 0);
        n_cmp++; if (o_wcount !== 0) begin n_bad++; $display("FAIL rs_zero_nowrite: got %0d writes want 0", o_wcount); end
        n_cmp++; if (o_rdata !== 64'hA5 || o_lat !== 2) begin n_bad++; $display("FAIL rs_zero_rsp: got %h lat %0d want a5 lat 2", o_rdata, o_lat); end
    endtask

    task automatic test_illegal_priv();
        do_op(3'b011, 12'h340, 64'h1, 5'd0, 1'b0, 2'b01, 0, 0);
        n_cmp++; if (o_ill !== 1'b1 || o_rdata !== 64'd0) begin n_bad++; $display("FAIL illegal_rsp: got %b/%h want 1/0", o_ill, o_rdata); end
        n_cmp++; if (o_wcount !== 0 || o_lat !== 2) begin n_bad++; $display("FAIL illegal_nowrite: got %0d writes lat %0d want 0 lat 2", o_wcount, o_lat); end
    endtask

    task automatic test_immediate();
        bank[12'h140] = 64'h01; ref_mem[12'h140] = 64'h01;
        do_op(3'b110, 12'h140, 64'hFFFF_FFFF, 5'h12, 1'b0, 2'b11, 0, 0);
        n_cmp++; if (o_wdata !== 64'h13 || o_wsel_s !== 1'b1 || o_wsel_m !== 1'b0 || o_wcount !== 1) begin
            n_bad++; $display("FAIL rsi: got %h s=%b m=%b cnt=%0d want 13 s=1 m=0 cnt=1", o_wdata, o_wsel_s, o_wsel_m, o_wcount); end
        do_op(3'b111, 12'h140, 64'h0, 5'h03, 1'b0, 2'b11, 0, 0);
        n_cmp++; if (o_wdata !== 64'h10 || o_rdata !== 64'h13) begin
            n_bad++; $display("FAIL rci: got data %h old %h want 10 old 13", o_wdata, o_rdata); end
        ref_mem[12'h140] = 64'h10;
    endtask

    task automatic test_back_to_back();
        do_op(3'b010, 12'h300, 64'h0, 5'd0, 1'b1, 2'b11, 4, 1);
        n_cmp++; if (o_stable !== 1'b1) begin n_bad++; $display("FAIL stall_stable: got %b want 1", o_stable); end
        n_cmp++; if (o_idle !== 1'b1 || o_rdata !== ref_mem[12'h300]) begin
            n_bad++; $display("FAIL stall_release: got idle=%b rdata=%h want 1 %h", o_idle, o_rdata, ref_mem[12'h300]); end
        do_op(3'b010, 12'h305, 64'h0, 5'd0, 1'b1, 2'b11, 0, 0);
        n_cmp++; if (o_timeout !== 1'b0 || o_rdata !== ref_mem[12'h305] || o_lat !== 2) begin
            n_bad++; $display("FAIL next_accept: got to=%b rdata=%h lat=%0d want 0 %h 2", o_timeout, o_rdata, o_lat, ref_mem[12'h305]); end
    endtask

    task automatic test_async_reset();
        bank[12'h340] = 64'h7; ref_mem[12'h340] = 64'h7;
        bus.req_valid = 1'b1; bus.req_op = 3'b001; bus.req_addr = 12'h340; bus.req_rs1_data = 64'h1234;
        bus.req_uimm = 5'd0; bus.req_rs1_zero = 1'b0; bus.priv = 2'b11;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (bus.csr_write !== 1'b1 || bus.mrw_mscratch_sel !== 1'b1) begin
            n_bad++; $display("FAIL arst_in_write: got wr=%b sel=%b want 1 1", bus.csr_write, bus.mrw_mscratch_sel); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.csr_write !== 1'b0 || bus.mrw_mscratch_sel !== 1'b0 || bus.srw_sscratch_sel !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL arst_immediate: got wr=%b m=%b s=%b v=%b want 0000", bus.csr_write,
                              bus.mrw_mscratch_sel, bus.srw_sscratch_sel, bus.rsp_valid); end
        @(posedge clk); #1 rst = 1'b0;
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1 || bus.csr_raddr !== 12'd0 || bus.data_csr !== 64'd0) begin
            n_bad++; $display("FAIL arst_release: got rdy=%b raddr=%h data=%h want 1 000 0", bus.req_ready, bus.csr_raddr, bus.data_csr); end
        do_op(3'b010, 12'h340, 64'h0, 5'd0, 1'b1, 2'b11, 0, 0);
        n_cmp++; if (o_rdata !== 64'h7 || o_lat !== 2) begin n_bad++; $display("FAIL arst_nowrite: got %h lat %0d want 7 lat 2", o_rdata, o_lat); end
    endtask

    task automatic test_random();
        logic [11:0] addrs [10] = '{12'h340, 12'h140, 12'h300, 12'h305, 12'h100,
                                    12'hC00, 12'hF14, 12'h7C0, 12'h123, 12'h341};
        for (int k = 0; k < 150; k++) begin
            logic [2:0]  op;
            logic [11:0] addr;
            logic [63:0] rs1, old, operand, nv, exp_rdata;
            logic [4:0]  uimm;
            logic        rs1z, wr, ill;
            logic [1:0]  pv;
            int          hold, exp_lat;
            op   = 3'($urandom_range(0, 7));
            addr = addrs[$urandom_range(0, 9)];
            rs1  = {$urandom, $urandom};
            uimm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rs1z = 1'($urandom);
            pv   = 2'($urandom_range(0, 2));
            if (pv == 2'b10) pv = 2'b11;
            hold = $urandom_range(0, 3);
            old     = ref_mem[addr];
            operand = op[2] ? {59'd0, uimm} : rs1;
            if (op == 3'b001 || op == 3'b101)      nv = operand;
            else if (op == 3'b010 || op == 3'b110) nv = old | operand;
            else                                   nv = old & ~operand;
            wr  = (op == 3'b001) || (op == 3'b101)
               || ((op == 3'b010 || op == 3'b011) && !rs1z)
               || ((op == 3'b110 || op == 3'b111) && uimm != 5'd0);
            ill = (op == 3'b000) || (op == 3'b100) || (addr[9:8] > pv)
               || (addr[11:10] == 2'b11 && wr)
               || !(addr == 12'h340 || addr == 12'h140 || ext_map[addr]);
            exp_lat   = (ill || !wr) ? 2 : 3;
            exp_rdata = ill ? 64'd0 : old;
            do_op(op, addr, rs1, uimm, rs1z, pv, hold, 1'($urandom));
            n_cmp++; if (o_timeout !== 1'b0 || o_lat !== exp_lat) begin
                n_bad++; $display("FAIL rnd%0d_latency: got %0d (to=%b) want %0d", k, o_lat, o_timeout, exp_lat); end
            n_cmp++; if (o_ill !== ill || o_rdata !== exp_rdata) begin
                n_bad++; $display("FAIL rnd%0d_rsp: got %b/%h want %b/%h", k, o_ill, o_rdata, ill, exp_rdata); end
            n_cmp++; if (o_wcount !== ((!ill && wr) ? 1 : 0) || o_stray !== 1'b0) begin
                n_bad++; $display("FAIL rnd%0d_wcount: got %0d stray=%b want %0d stray=0", k, o_wcount, o_stray, (!ill && wr) ? 1 : 0); end
            if (!ill && wr) begin
                n_cmp++; if (o_wdata !== nv || o_wsel_m !== (addr == 12'h340) || o_wsel_s !== (addr == 12'h140)) begin
                    n_bad++; $display("FAIL rnd%0d_wdata: got %h m=%b s=%b want %h m=%b s=%b", k, o_wdata, o_wsel_m,
                                      o_wsel_s, nv, addr == 12'h340, addr == 12'h140); end
                ref_mem[addr] = nv;
            end
            n_cmp++; if (o_stable !== 1'b1 || o_idle !== 1'b1) begin
                n_bad++; $display("FAIL rnd%0d_handshake: got stable=%b idle=%b want 1 1", k, o_stable, o_idle); end
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        for (int i = 0; i < 4096; i++) begin
            bank[i]    = {$urandom, $urandom};
            ref_mem[i] = bank[i];
            ext_map[i] = 1'b0;
        end
        ext_map[12'h300] = 1'b1; ext_map[12'h305] = 1'b1; ext_map[12'h100] = 1'b1;
        ext_map[12'hC00] = 1'b1; ext_map[12'hF14] = 1'b1; ext_map[12'h341] = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_addr = 12'd0; bus.req_rs1_data = '0;
        bus.req_uimm = 5'd0; bus.req_rs1_zero = 1'b0; bus.priv = 2'b11; bus.rsp_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_csrrw_mscratch();
        test_read_only();
        test_illegal_priv();
        test_immediate();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
